// File: rtl/scan_tester.sv
// Scan chain tester: loads a pattern into an external scan chain, runs functional capture
// cycles, unloads the response and compares it against a masked expected value.
module scan_tester #(
    parameter int CHAIN_LEN      = 16,
    parameter int CAPTURE_CYCLES = 1,
    localparam int CNT_W         = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expect_in,
    input  logic [CHAIN_LEN-1:0] mask_in,
    input  logic                 scan_data_out,
    output logic                 scan_enable,
    output logic                 scan_data_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [CNT_W-1:0]     mismatch_count
);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;

    state_t               state;
    logic [6:0]           ctr;
    logic [CHAIN_LEN-1:0] pattern_q;
    logic [CHAIN_LEN-1:0] expect_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic [CHAIN_LEN-1:0] unload_q;
    logic [CHAIN_LEN-1:0] unload_full;
    logic [CNT_W-1:0]     miss_now;

    function automatic logic [CNT_W-1:0] popcount(input logic [CHAIN_LEN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // The final chain bit arrives in the DONE cycle, so the result is formed from it directly.
    always_comb begin
        unload_full = {unload_q[CHAIN_LEN-2:0], scan_data_out};
        miss_now    = popcount((unload_full ^ expect_q) & mask_q);
    end

    assign busy = (state != IDLE);

    // Scan outputs are registered from the current state, so the pin activity trails the
    // state by one cycle; unload sampling is shifted by one count to line up with it.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            ctr            <= '0;
            scan_enable    <= 1'b0;
            scan_data_in   <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            pattern_q      <= '0;
            expect_q       <= '0;
            mask_q         <= '0;
            unload_q       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    scan_enable  <= 1'b0;
                    scan_data_in <= 1'b0;
                    if (start) begin
                        pattern_q <= pattern_in;
                        expect_q  <= expect_in;
                        mask_q    <= mask_in;
                        ctr       <= '0;
                        state     <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    scan_enable  <= 1'b1;
                    scan_data_in <= pattern_q[CHAIN_LEN-1];
                    pattern_q    <= pattern_q << 1;
                    if (ctr == 7'(CHAIN_LEN - 1)) begin
                        ctr   <= '0;
                        state <= CAPTURE;
                    end else begin
                        ctr <= ctr + 7'd1;
                    end
                end
                CAPTURE: begin
                    scan_enable  <= 1'b0;
                    scan_data_in <= 1'b0;
                    if (ctr == 7'(CAPTURE_CYCLES - 1)) begin
                        ctr   <= '0;
                        state <= SHIFT_OUT;
                    end else begin
                        ctr <= ctr + 7'd1;
                    end
                end
                SHIFT_OUT: begin
                    scan_enable  <= 1'b1;
                    scan_data_in <= 1'b0;
                    if (ctr != '0) begin
                        unload_q <= {unload_q[CHAIN_LEN-2:0], scan_data_out};
                    end
                    if (ctr == 7'(CHAIN_LEN - 1)) begin
                        ctr   <= '0;
                        state <= DONE;
                    end else begin
                        ctr <= ctr + 7'd1;
                    end
                end
                DONE: begin
                    scan_enable    <= 1'b0;
                    scan_data_in   <= 1'b0;
                    done           <= 1'b1;
                    captured       <= unload_full;
                    mismatch_count <= miss_now;
                    pass           <= (miss_now == '0);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
